aes_ocl_ctrl: RTL

//  AXI-Lite (OCL BAR0) register front-end for a fixed-latency pipelined AES core.

---
 rtl/aes_ocl_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_ocl_ctrl.sv
// AXI-Lite register front-end for a fixed-latency AES core: key/plaintext load,
// START/CLR control, status and job counter, ciphertext capture, virtual-LED mux.
module aes_ocl_ctrl #(
    parameter int          ADDR_W     = 32,
    parameter int          KEY_WORDS  = 8,
    parameter int          CORE_LAT   = 30,
    parameter logic [31:0] UNIMPL_VAL = 32'hDEAD_DEEF,
    parameter logic [31:0] ID_VAL     = 32'hAE50_0100
) (
    input  logic                    clk_main_a0,
    input  logic                    rst_main,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ADDR_W-1:0]       s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [ADDR_W-1:0]       s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic [127:0]            aes_state,
    output logic [32*KEY_WORDS-1:0] aes_key,
    input  logic [127:0]            aes_out,
    output logic [15:0]             vled
);
    localparam int               CNT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_RUN   = 1'b1;
    localparam logic [5:0]       A_ID = 6'h00, A_CTRL = 6'h01, A_STATUS = 6'h02, A_JOBS = 6'h03;
    localparam logic [5:0]       A_KEY = 6'h04, A_PT = 6'h0C, A_CT = 6'h10, A_VSEL = 6'h14;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] wd,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic             wr_active_q, wr_active_d;
    logic [5:0]       awidx_q, awidx_d;
    logic             bvalid_q, bvalid_d;
    logic             ar_q, ar_d;
    logic [5:0]       aridx_q, aridx_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      jobs_q, jobs_d;
    logic [31:0]      key_q [KEY_WORDS];
    logic [31:0]      key_d [KEY_WORDS];
    logic [31:0]      pt_q [4];
    logic [31:0]      pt_d [4];
    logic [31:0]      ct_q [4];
    logic [31:0]      ct_d [4];
    logic             vsel_q, vsel_d;
    logic [15:0]      vled_q, vled_d;
    logic [31:0]      rd_mux;
    logic             w_fire, ar_fire, busy, ctrl_wr;
    logic             unused_addr;

    assign s_awready = ~wr_active_q;
    // W is only taken after AW, and only once per write until the B handshake.
    assign s_wready  = wr_active_q & ~bvalid_q & s_wvalid;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = 2'b00;
    assign s_arready = ~ar_q & ~rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = 2'b00;
    assign w_fire    = s_wready;
    assign ar_fire   = s_arvalid & s_arready;
    assign busy      = (state_q == ST_RUN);
    assign ctrl_wr   = w_fire & (awidx_q == A_CTRL) & s_wstrb[0];
    assign aes_state = {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};
    assign vled      = vled_q;
    assign vled_d    = vsel_q ? jobs_q[15:0] : ct_q[0][15:0];
    assign unused_addr = ^{s_awaddr[ADDR_W-1:8], s_awaddr[1:0], s_araddr[ADDR_W-1:8], s_araddr[1:0]};

    for (genvar k = 0; k < KEY_WORDS; k++) begin : g_key
        assign aes_key[32*k +: 32] = key_q[k];
    end

    always_comb begin
        wr_active_d = wr_active_q;
        awidx_d     = awidx_q;
        bvalid_d    = bvalid_q;
        ar_d        = ar_q;
        aridx_d     = aridx_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        if (s_awvalid && s_awready) begin
            wr_active_d = 1'b1;
            awidx_d     = s_awaddr[7:2];
        end
        if (w_fire) bvalid_d = 1'b1;
        if (bvalid_q && s_bready) begin
            bvalid_d    = 1'b0;
            wr_active_d = 1'b0;
        end
        if (ar_fire) begin
            ar_d    = 1'b1;
            aridx_d = s_araddr[7:2];
        end
        if (ar_q) begin
            ar_d     = 1'b0;
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end
        if (rvalid_q && s_rready) rvalid_d = 1'b0;
    end

    always_comb begin
        rd_mux = UNIMPL_VAL;
        case (aridx_q)
            A_ID:     rd_mux = ID_VAL;
            A_CTRL:   rd_mux = '0;
            A_STATUS: rd_mux = {29'd0, err_q, done_q, busy};
            A_JOBS:   rd_mux = jobs_q;
            A_VSEL:   rd_mux = {31'd0, vsel_q};
            default:  ;
        endcase
        for (int k = 0; k < KEY_WORDS; k++)
            if (aridx_q == A_KEY + 6'(k)) rd_mux = key_q[k];
        for (int k = 0; k < 4; k++) begin
            if (aridx_q == A_PT + 6'(k)) rd_mux = pt_q[k];
            if (aridx_q == A_CT + 6'(k)) rd_mux = ct_q[k];
        end
    end

    // CLR is applied before anything else in the beat so a same-beat START or
    // a rejected write can still leave err set afterwards.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        jobs_d  = jobs_q;
        key_d   = key_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        vsel_d  = vsel_q;
        if (ctrl_wr && s_wdata[1]) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (w_fire) begin
            for (int k = 0; k < KEY_WORDS; k++)
                if (awidx_q == A_KEY + 6'(k)) begin
                    if (busy) err_d = 1'b1;
                    else      key_d[k] = merge_bytes(key_q[k], s_wdata, s_wstrb);
                end
            for (int k = 0; k < 4; k++)
                if (awidx_q == A_PT + 6'(k)) begin
                    if (busy) err_d = 1'b1;
                    else      pt_d[k] = merge_bytes(pt_q[k], s_wdata, s_wstrb);
                end
            if (awidx_q == A_VSEL && s_wstrb[0]) vsel_d = s_wdata[0];
        end
        if (ctrl_wr && s_wdata[0]) begin
            if (busy) begin
                err_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                cnt_d   = CNT_LOAD;
                done_d  = 1'b0;
            end
        end
        if (busy) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                jobs_d  = jobs_q + 32'd1;
                for (int k = 0; k < 4; k++) ct_d[k] = aes_out[32*k +: 32];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            wr_active_q <= 1'b0;
            awidx_q     <= '0;
            bvalid_q    <= 1'b0;
            ar_q        <= 1'b0;
            aridx_q     <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            jobs_q      <= '0;
            vsel_q      <= 1'b0;
            vled_q      <= '0;
            for (int k = 0; k < KEY_WORDS; k++) key_q[k] <= '0;
            for (int k = 0; k < 4; k++) begin
                pt_q[k] <= '0;
                ct_q[k] <= '0;
            end
        end else begin
            wr_active_q <= wr_active_d;
            awidx_q     <= awidx_d;
            bvalid_q    <= bvalid_d;
            ar_q        <= ar_d;
            aridx_q     <= aridx_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            jobs_q      <= jobs_d;
            vsel_q      <= vsel_d;
            vled_q      <= vled_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
        end
    end
endmodule
